edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
Multi-channel edge-event controller. It runs edge detection on N level inputs and queues one pending event per channel. A round-robin scheduler then shares a single valid/ready event port among the channels. The block sits between raw status lines and a downstream consumer (interrupt logic or event logger) that accepts at most one event per cycle.

Parameters:
N, 4, number of input channels (2..16)
IDX_W, 2, channel index width; must equal clog2(N)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
a  input  N  level inputs, already synchronous to clk
en_rise  input  N  per-channel enable for rising-edge events
en_fall  input  N  per-channel enable for falling-edge events
evt_valid  output  1  event available on evt_ch/evt_type
evt_ready  input  1  consumer accepts event when high with evt_valid
evt_ch  output  IDX_W  channel index of presented event
evt_type  output  1  1 = rising edge, 0 = falling edge
overflow  output  N  sticky per-channel drop flag
clr_ovf  input  1  one-cycle pulse, clears all overflow bits

Behaviour:
- Reset (async, rst=1): a_d=0, prime=1, all pending slots empty, rr_ptr=0, evt_valid=0, evt_ch=0, evt_type=0, overflow=0.
- Prime cycle: on the first clock edge after reset deassertion, a_d loads a, no edges are detected, and prime clears. An input held high through reset produces no event.
- Detection: rise[i] = a[i] & ~a_d[i] & en_rise[i]; fall[i] = ~a[i] & a_d[i] & en_fall[i]. a_d loads a on every edge.
- Disabled edge types are ignored: no pend, no overflow. Changing en_* does not alter slots already pending.
- Pending slot per channel holds pend[i] and ptype[i]. It is set at the same edge where the edge is detected.
- Slot occupied and not granted this cycle, new enabled edge arrives: the new edge is dropped, the old event is kept, and overflow[i] is set.
- Slot granted this cycle and new edge arrives on the same channel in the same cycle: the new edge is stored, no overflow.
- Output register load condition: load = ~evt_valid | evt_ready.
- Grant: when load is true and any pend is set, pick the first pending channel scanning rr_ptr, rr_ptr+1, ... wrapping modulo N.
- On grant:
  - evt_ch and evt_type load from that slot; evt_valid=1.
  - That slot clears.
  - rr_ptr = granted+1 mod N, wrapping to 0 when N-1 is granted.
- When load is true and nothing is pending: evt_valid=0 on the next edge. evt_ch and evt_type hold their last values.
- While evt_valid=1 and evt_ready=0: evt_valid, evt_ch and evt_type are held stable, and no slot is cleared.
- Latency: an edge present before clock edge E0 pends at E0. With the output free, evt_valid rises after E1, a 2-cycle minimum.
- Throughput: one event per cycle with evt_ready held high.
- Overflow bits are sticky. clr_ovf clears all of them. A new overflow in the same cycle as clr_ovf wins, so that bit stays set.
- Both edges within one channel stay ordered: a second edge is stored only once the first has been granted.
- Reset asserted mid-transfer: everything returns to reset values immediately, and the presented event is lost.

Test Plan:
- Prime: a=4'b0101 held through reset, en_rise=en_fall=4'hF, release rst → no evt_valid for 10 cycles, overflow=0.
- Single rise: a[2] 0→1, evt_ready=1 → evt_valid=1 two edges later for exactly one cycle, evt_ch=2, evt_type=1. Then a[2] 1→0 → evt_ch=2, evt_type=0.
- Round-robin: evt_ready=0, rise on ch0, ch1 and ch3 in the same cycle, then evt_ready=1 → events in order ch0, ch1, ch3 on consecutive cycles. Next simultaneous ch0+ch3 rise → ch0 first (rr_ptr wrapped to 0).
- Backpressure and overflow: evt_ready=0, ch1 rises while its event is presented (slot reloads), then ch1 falls → overflow=4'b0010, the pending event is the rise. clr_ovf pulse → overflow=0. clr_ovf in the same cycle as a new drop → bit stays 1.
- Enables: en_fall=0, toggle a[0] 0→1→0 → exactly one event (ch0, type 1), no overflow.
- Mid-operation reset: evt_valid=1 held with evt_ready=0, pulse rst → evt_valid=0 and overflow=0 immediately; no stale event appears after release.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event arbiter.
// Detects enabled rising/falling edges on N synchronous level inputs and keeps
// one pending event per channel. A round-robin scheduler then presents these
// events one at a time on a single valid/ready port. A per-channel sticky flag
// records every edge that was dropped because its channel slot was still full.
module edge_event_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     en_rise,
   input  logic [N-1:0]     en_fall,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_ch,
   output logic             evt_type,
   output logic [N-1:0]     overflow,
   input  logic             clr_ovf
);

   // The scan index needs one extra bit so rr_ptr + offset can be reduced modulo N.
   localparam int CW = IDX_W + 1;

   // Input history and the prime flag that masks the first compare after reset.
   logic [N-1:0]     a_d;
   logic             prime;

   // Edge detection results.
   logic [N-1:0]     rise;
   logic [N-1:0]     fall;
   logic [N-1:0]     edge_det;

   // Pending event slots, one per channel.
   logic [N-1:0]     pend;
   logic [N-1:0]     ptype;

   // Scheduler state and grant decision.
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;
   logic             load;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic [CW-1:0]    cand;
   logic [N-1:0]     granted;
   logic [N-1:0]     slot_free;
   logic [N-1:0]     drop;

   // Qualify raw edges with their enables; suppress all edges during the prime cycle.
   always_comb begin
      rise     = a & ~a_d & en_rise & {N{~prime}};
      fall     = ~a & a_d & en_fall & {N{~prime}};
      edge_det = rise | fall;
   end

   // Capture the previous input level every cycle; prime only survives one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_d   <= '0;
         prime <= 1'b1;
      end else begin
         a_d   <= a;
         prime <= 1'b0;
      end
   end

   // The output register may take a new event when empty or when the consumer accepts.
   assign load = ~evt_valid | evt_ready;

   // Round-robin scan: first pending channel at or after rr_ptr, wrapping modulo N.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr} + CW'(k);
         if (cand >= CW'(N)) begin
            cand = cand - CW'(N);
         end
         if (!gnt_vld && pend[cand[IDX_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
         end
      end
   end

   // Pointer after a grant: one past the winner, wrapping after channel N-1.
   always_comb begin
      if (gnt_idx == IDX_W'(N - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = gnt_idx + 1'b1;
      end
   end

   // Per-channel grant strobe and slot bookkeeping.
   // A slot accepts a new edge when empty or when it is being handed out this
   // cycle; otherwise the new edge is dropped so the older event keeps its order.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         granted[i] = load & gnt_vld & (gnt_idx == IDX_W'(i));
      end
      slot_free = ~pend | granted;
      drop      = pend & ~granted & edge_det;
   end

   // Pending slots: store a new edge into a free slot, or clear a granted slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= '0;
         ptype <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (slot_free[i]) begin
               if (edge_det[i]) begin
                  pend[i]  <= 1'b1;
                  ptype[i] <= rise[i];
               end else if (granted[i]) begin
                  pend[i]  <= 1'b0;
               end
            end
         end
      end
   end

   // Output register and round-robin pointer; contents hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_type  <= 1'b0;
         rr_ptr    <= '0;
      end else if (load) begin
         if (gnt_vld) begin
            evt_valid <= 1'b1;
            evt_ch    <= gnt_idx;
            evt_type  <= ptype[gnt_idx];
            rr_ptr    <= rr_next;
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

   // Sticky drop flags; a drop in the same cycle as a clear keeps its bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= '0;
      end else begin
         overflow <= (clr_ovf ? '0 : overflow) | drop;
      end
   end

endmodule
